atom_ingress_stage: RTL
=======================

Name: atom_ingress_stage

Overview:
Ingress stage that sits directly upstream of the read/write stateful atom. It accepts packet fields over a valid/ready handshake, buffers them in a small FIFO, and holds the atom's constant operand in a config register. It presents at most one packet per cycle to the atom's packet-field, select and constant inputs, with an update-valid and a downstream stall. It also keeps a wrapping count of packets issued to the atom.

Parameters:
COUNT_WIDTH, 3, width of packet field and constant; matches the atom's data width
DEPTH, 2, FIFO entries; must be ≥1 and a power of two
STAT_WIDTH, 8, width of the issued-packet counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
i__pkt_valid  input  1  upstream packet present
i__pkt_field  input  COUNT_WIDTH  packet field for the atom's packet input
i__pkt_sel  input  1  atom mux select: 0 = constant, 1 = packet field
o__pkt_ready  output  1  stage can accept a packet this cycle
i__cfg_we  input  1  load constant register
i__cfg_constant  input  COUNT_WIDTH  new constant value
i__stall  input  1  atom/downstream cannot take an update this cycle
o__valid  output  1  head packet presented; the atom register updates only when o__valid && !i__stall
o__pkt_1  output  COUNT_WIDTH  head packet field
o__sel  output  1  head packet select
o__constant  output  COUNT_WIDTH  current constant register
o__issued_count  output  STAT_WIDTH  packets issued since reset, wraps

Behaviour:
- Reset (async assert, sync deassert handled by the top level): FIFO occupancy = 0, rd/wr pointers = 0, constant = 0, issued_count = 0.
- While rst = 1: o__valid = 0 and o__pkt_ready = 0. o__pkt_1 and o__sel are don't-care but must drive 0.
- push = i__pkt_valid && o__pkt_ready. pop = o__valid && !i__stall.
- o__pkt_ready = (occupancy < DEPTH) && !rst. It depends only on state, with no combinational path from i__stall or i__pkt_valid.
- o__valid = (occupancy != 0). o__pkt_1 and o__sel come combinationally from the head entry.
- Latency: a packet pushed in cycle N is presented at the earliest in cycle N+1. There is no same-cycle bypass when the FIFO is empty.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
- Full (occupancy = DEPTH): ready = 0, so a push cannot occur. A pop in this cycle raises ready in the next cycle, not the current one.
- Empty: o__valid = 0, pop impossible, and a held i__stall has no effect.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- FIFO ordering: strict FIFO; entries are never reordered or dropped.
- Stall: while i__stall = 1, the head entry and o__valid stay stable. A held packet must not change while stalled.
- Constant register: loads i__cfg_constant on the clk edge where i__cfg_we = 1, so the new value is visible on the next cycle. A packet popped in the same cycle as i__cfg_we is paired with the old constant.
- o__issued_count: increments by 1 on each pop, wrapping from 2^STAT_WIDTH−1 to 0.
- Reset mid-operation: all buffered packets are discarded and never issued. The constant returns to 0.

Decomposition:
- Package atom_pkg:
  - COUNT_WIDTH default constant
  - typedef atom_entry_t, a struct of {field [COUNT_WIDTH-1:0], sel}
  - function clog2-based pointer width
- One sub-module atom_fifo: parameterised by DEPTH and the atom_entry_t payload. Ports are push/pop/full/empty/head, with the same async active-high reset.
- atom_ingress_stage instantiates atom_fifo and owns the constant register and the issued counter.

Test Plan:
- Reset then idle: after rst deassert, o__pkt_ready = 1, o__valid = 0, o__constant = 0, o__issued_count = 0.
- Single packet, no stall: push {field=5, sel=1} at cycle 1. Cycle 2: o__valid = 1, o__pkt_1 = 5, o__sel = 1. Cycle 3: o__valid = 0, count = 1.
- Fill and stall:
  - Hold i__stall = 1 and push 3 then 6.
  - After the second push, o__pkt_ready = 0 and the head stays at 3 for 5 stalled cycles.
  - Release the stall: issue 3 then 6 in consecutive cycles. Ready returns the cycle after the first pop.
- Constant update race: cfg_we with constant=7 in the same cycle as a pop of {2, sel=0}. That pop sees o__constant = 0. The next cycle shows o__constant = 7.
- Counter wrap: with STAT_WIDTH = 2, issue 5 packets, giving o__issued_count sequence 1, 2, 3, 0, 1.
- Reset mid-operation: with 2 entries buffered and constant = 4, assert rst asynchronously between edges. Outputs go to o__valid = 0, o__pkt_ready = 0 and o__constant = 0 immediately. After release, no stale packet is issued.

Source files
------------

// File: rtl/atom_pkg.sv
// Shared types and helpers for the atom ingress stage.
package atom_pkg;

  localparam int unsigned ATOM_COUNT_WIDTH = 3;

  typedef struct packed {
    logic [ATOM_COUNT_WIDTH-1:0] field;
    logic                        sel;
  } atom_entry_t;

  // A single-entry FIFO still needs a one-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/atom_fifo.sv
// Small strict-order FIFO with async active-high reset; head is read combinationally.
module atom_fifo
  import atom_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = atom_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_data,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  entry_t            mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   occ_q;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (occ_q == CntW'(DEPTH));
  assign empty   = (occ_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      occ_q <= occ_q + CntW'(1);
      else if (do_pop && !do_push) occ_q <= occ_q - CntW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/atom_ingress_stage.sv
// Buffers packets ahead of the stateful atom, holds its constant operand, counts issues.
module atom_ingress_stage
  import atom_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = ATOM_COUNT_WIDTH,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned STAT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i__pkt_valid,
  input  logic [COUNT_WIDTH-1:0] i__pkt_field,
  input  logic                   i__pkt_sel,
  output logic                   o__pkt_ready,
  input  logic                   i__cfg_we,
  input  logic [COUNT_WIDTH-1:0] i__cfg_constant,
  input  logic                   i__stall,
  output logic                   o__valid,
  output logic [COUNT_WIDTH-1:0] o__pkt_1,
  output logic                   o__sel,
  output logic [COUNT_WIDTH-1:0] o__constant,
  output logic [STAT_WIDTH-1:0]  o__issued_count
);

  atom_entry_t            in_entry, head_entry;
  logic                   full, empty, push, pop;
  logic [COUNT_WIDTH-1:0] constant_q;
  logic [STAT_WIDTH-1:0]  issued_q;

  assign in_entry.field = i__pkt_field;
  assign in_entry.sel   = i__pkt_sel;

  // Ready is a function of state and reset only, never of stall or valid.
  assign o__pkt_ready = !full && !rst;
  assign o__valid     = !empty;
  assign push         = i__pkt_valid && o__pkt_ready;
  assign pop          = o__valid && !i__stall;

  // Storage is not reset, so mask the head whenever nothing is presented.
  assign o__pkt_1 = o__valid ? head_entry.field : '0;
  assign o__sel   = o__valid && head_entry.sel;

  assign o__constant     = constant_q;
  assign o__issued_count = issued_q;

  atom_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (atom_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_entry),
    .head    (head_entry),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      constant_q <= '0;
      issued_q   <= '0;
    end else begin
      if (i__cfg_we) constant_q <= i__cfg_constant;
      if (pop)       issued_q   <= issued_q + STAT_WIDTH'(1);
    end
  end

endmodule
